msu_sq_sequencer: RTL and testbench

Single-clock, parametrised front end for the modular squaring core. It captures a non-redundant input value and splits it into redundant polynomial coefficients. It then drives the squarer for a programmable number of back-to-back iterations, feeding each result straight back as the next input, and packs the final coefficients into a wide output word. Configurable transit pipelines on the input and output paths ease placement across the FPGA. A graceful stop request ends a run early and reports how many iterations completed.

---
 rtl/msu_sq_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_msu_sq_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_sq_sequencer.sv
// Front end for the modular squaring core: splits the input into redundant coefficients,
// iterates the squarer with direct feedback, and packs the final coefficients for output.
module msu_sq_sequencer #(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = 16,
  parameter int BIT_LEN            = 17,
  parameter int REDUNDANT_ELEMENTS = 2,
  parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
  parameter int OUT_COEF_LEN       = 2 * WORD_LEN,
  parameter int ITER_BITS          = 32,
  parameter int IN_STAGES          = 4,
  parameter int OUT_STAGES         = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [MOD_LEN-1:0]                   sq_in,
  input  logic [ITER_BITS-1:0]                 iterations,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_ELEMENTS*OUT_COEF_LEN-1:0] sq_out,
  output logic [ITER_BITS-1:0]                 iter_count,
  output logic                                 sqr_start,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0]      sqr_in,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0]      sqr_out,
  input  logic                                 sqr_valid
);

  localparam int NW = MOD_LEN / WORD_LEN;
  localparam int CW = NUM_ELEMENTS * BIT_LEN;
  localparam int OW = NUM_ELEMENTS * OUT_COEF_LEN;
  localparam logic [7:0] IN_LAST = 8'(IN_STAGES);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_t;

  function automatic logic [CW-1:0] split_coefs(input logic [MOD_LEN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < NW; j++)
      c[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(v[j*WORD_LEN +: WORD_LEN]);
    return c;
  endfunction

  function automatic logic [OW-1:0] pack_coefs(input logic [CW-1:0] c);
    logic [OW-1:0] o;
    o = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      o[j*OUT_COEF_LEN +: OUT_COEF_LEN] = OUT_COEF_LEN'(c[j*BIT_LEN +: BIT_LEN]);
    return o;
  endfunction

  state_t               state;
  logic                 stop_lat;
  logic [CW-1:0]        coef_cap;
  logic [CW-1:0]        coef_loaded;
  logic [ITER_BITS-1:0] iters;
  logic [ITER_BITS-1:0] cnt;
  logic [7:0]           load_cnt;

  logic                 accept;
  logic                 stop_eff;
  logic                 drain_fire;
  logic [CW-1:0]        drain_data;
  logic [ITER_BITS-1:0] drain_cnt;

  logic                 vld_tail;
  logic [CW-1:0]        res_tail;
  logic [ITER_BITS-1:0] cnt_tail;

  assign accept   = (state == IDLE) && start && !busy;
  assign stop_eff = stop_lat | stop;

  // A result leaves either straight from LOAD (nothing to square) or from the final sqr_valid.
  always_comb begin
    drain_fire = 1'b0;
    drain_data = coef_loaded;
    drain_cnt  = cnt;
    case (state)
      LOAD: begin
        if (load_cnt == IN_LAST && (iters == '0 || stop_eff))
          drain_fire = 1'b1;
      end
      WAIT: begin
        drain_data = sqr_out;
        drain_cnt  = cnt + ITER_BITS'(1);
        if (sqr_valid && (cnt + ITER_BITS'(1) == iters || stop_eff))
          drain_fire = 1'b1;
      end
      default: ;
    endcase
  end

  // Input transit stages: capture register followed by IN_STAGES plain registers
  generate
    if (IN_STAGES == 0) begin : g_in_direct
      assign coef_loaded = coef_cap;
    end else begin : g_in_pipe
      logic [CW-1:0] coef_p [IN_STAGES];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < IN_STAGES; k++) coef_p[k] <= '0;
        end else begin
          coef_p[0] <= coef_cap;
          for (int k = 1; k < IN_STAGES; k++) coef_p[k] <= coef_p[k-1];
        end
      end
      assign coef_loaded = coef_p[IN_STAGES-1];
    end
  endgenerate

  // Output transit stages: result, count and valid travel together
  generate
    if (OUT_STAGES == 0) begin : g_out_direct
      assign vld_tail = drain_fire;
      assign res_tail = drain_data;
      assign cnt_tail = drain_cnt;
    end else begin : g_out_pipe
      logic                 vld_p [OUT_STAGES];
      logic [CW-1:0]        res_p [OUT_STAGES];
      logic [ITER_BITS-1:0] cnt_p [OUT_STAGES];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < OUT_STAGES; k++) begin
            vld_p[k] <= 1'b0;
            res_p[k] <= '0;
            cnt_p[k] <= '0;
          end
        end else begin
          vld_p[0] <= drain_fire;
          res_p[0] <= drain_data;
          cnt_p[0] <= drain_cnt;
          for (int k = 1; k < OUT_STAGES; k++) begin
            vld_p[k] <= vld_p[k-1];
            res_p[k] <= res_p[k-1];
            cnt_p[k] <= cnt_p[k-1];
          end
        end
      end
      assign vld_tail = vld_p[OUT_STAGES-1];
      assign res_tail = res_p[OUT_STAGES-1];
      assign cnt_tail = cnt_p[OUT_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sqr_start  <= 1'b0;
      sqr_in     <= '0;
      sq_out     <= '0;
      iter_count <= '0;
      stop_lat   <= 1'b0;
      coef_cap   <= '0;
      iters      <= '0;
      cnt        <= '0;
      load_cnt   <= '0;
    end else begin
      done      <= vld_tail;
      sqr_start <= 1'b0;
      if (vld_tail) begin
        sq_out     <= pack_coefs(res_tail);
        iter_count <= cnt_tail;
      end
      if (done)        busy <= 1'b0;
      else if (accept) busy <= 1'b1;
      if (accept)                       stop_lat <= 1'b0;
      else if (state != IDLE && stop)   stop_lat <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            coef_cap <= split_coefs(sq_in);
            iters    <= iterations;
            cnt      <= '0;
            load_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt == IN_LAST) begin
            if (drain_fire) begin
              state <= (OUT_STAGES == 0) ? IDLE : DRAIN;
            end else begin
              sqr_in    <= coef_loaded;
              sqr_start <= 1'b1;
              state     <= ISSUE;
            end
          end else begin
            load_cnt <= load_cnt + 8'd1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (sqr_valid) begin
            cnt <= cnt + ITER_BITS'(1);
            if (drain_fire) begin
              state <= (OUT_STAGES == 0) ? IDLE : DRAIN;
            end else begin
              sqr_in    <= sqr_out;
              sqr_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DRAIN: if (vld_tail) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_sq_sequencer.sv
// Directed bench for msu_sq_sequencer: one instance with 4/4 transit stages, one with 0/0,
// each driven against a 3-cycle "add one per coefficient" squarer model.
module tb_msu_sq_sequencer;

  localparam int CW = 68;
  localparam int OW = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] inc_coefs(input logic [CW-1:0] c);
    logic [CW-1:0] o;
    for (int j = 0; j < 4; j++) o[j*17 +: 17] = c[j*17 +: 17] + 17'd1;
    return o;
  endfunction

  function automatic logic [OW-1:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // ---------------- instance A: IN_STAGES=4, OUT_STAGES=4 ----------------
  logic          start_a = 0, stop_a = 0, spur_a = 0;
  logic [31:0]   sq_in_a = 0, iters_a = 0;
  logic          busy_a, done_a, sqr_start_a, sqr_valid_a;
  logic [OW-1:0] sq_out_a;
  logic [31:0]   iter_count_a;
  logic [CW-1:0] sqr_in_a, sqr_out_a;
  logic [2:0]    v_a;

  msu_sq_sequencer #(.MOD_LEN(32), .WORD_LEN(16), .BIT_LEN(17), .REDUNDANT_ELEMENTS(2),
    .NUM_ELEMENTS(4), .OUT_COEF_LEN(32), .ITER_BITS(32), .IN_STAGES(4), .OUT_STAGES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .sq_in(sq_in_a),
    .iterations(iters_a), .busy(busy_a), .done(done_a), .sq_out(sq_out_a),
    .iter_count(iter_count_a), .sqr_start(sqr_start_a), .sqr_in(sqr_in_a),
    .sqr_out(sqr_out_a), .sqr_valid(sqr_valid_a));

  always @(posedge clk or posedge reset)
    if (reset) v_a <= '0; else v_a <= {v_a[1:0], sqr_start_a};
  assign sqr_valid_a = v_a[2] | spur_a;
  assign sqr_out_a   = inc_coefs(sqr_in_a);

  // ---------------- instance B: IN_STAGES=0, OUT_STAGES=0 ----------------
  logic          start_b = 0, stop_b = 0;
  logic [31:0]   sq_in_b = 0, iters_b = 0;
  logic          busy_b, done_b, sqr_start_b, sqr_valid_b;
  logic [OW-1:0] sq_out_b;
  logic [31:0]   iter_count_b;
  logic [CW-1:0] sqr_in_b, sqr_out_b;
  logic [2:0]    v_b;

  msu_sq_sequencer #(.MOD_LEN(32), .WORD_LEN(16), .BIT_LEN(17), .REDUNDANT_ELEMENTS(2),
    .NUM_ELEMENTS(4), .OUT_COEF_LEN(32), .ITER_BITS(32), .IN_STAGES(0), .OUT_STAGES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .sq_in(sq_in_b),
    .iterations(iters_b), .busy(busy_b), .done(done_b), .sq_out(sq_out_b),
    .iter_count(iter_count_b), .sqr_start(sqr_start_b), .sqr_in(sqr_in_b),
    .sqr_out(sqr_out_b), .sqr_valid(sqr_valid_b));

  always @(posedge clk or posedge reset)
    if (reset) v_b <= '0; else v_b <= {v_b[1:0], sqr_start_b};
  assign sqr_valid_b = v_b[2];
  assign sqr_out_b   = inc_coefs(sqr_in_b);

  // ---------------- monitors (sampled on the falling edge) ----------------
  int ns_a = 0, nd_a = 0, gap_bad_a = 0, first_st_a = -1, last_st_a = -1, done_cyc_a = -1;
  int ns_b = 0, nd_b = 0, gap_bad_b = 0, first_st_b = -1, last_st_b = -1, done_cyc_b = -1;
  logic [OW-1:0] out_a, out_b;
  logic [31:0]   cnt_a, cnt_b;
  logic [OW-1:0] out_log_a [2];
  logic [31:0]   cnt_log_a [2];

  always @(negedge clk) begin
    if (sqr_start_a) begin
      if (ns_a > 0 && cyc - last_st_a != 4) gap_bad_a++;
      if (ns_a == 0) first_st_a = cyc;
      last_st_a = cyc;
      ns_a++;
    end
    if (done_a) begin
      if (nd_a < 2) begin
        out_log_a[nd_a] = sq_out_a;
        cnt_log_a[nd_a] = iter_count_a;
      end
      out_a = sq_out_a;
      cnt_a = iter_count_a;
      done_cyc_a = cyc;
      nd_a++;
    end
    if (sqr_start_b) begin
      if (ns_b > 0 && cyc - last_st_b != 4) gap_bad_b++;
      if (ns_b == 0) first_st_b = cyc;
      last_st_b = cyc;
      ns_b++;
    end
    if (done_b) begin
      out_b = sq_out_b;
      cnt_b = iter_count_b;
      done_cyc_b = cyc;
      nd_b++;
    end
  end

  task automatic clear_mon;
    ns_a = 0; nd_a = 0; gap_bad_a = 0; first_st_a = -1; done_cyc_a = -1;
    ns_b = 0; nd_b = 0; gap_bad_b = 0; first_st_b = -1; done_cyc_b = -1;
  endtask

  task automatic launch_a(input logic [31:0] sq, input logic [31:0] it, output int c);
    @(posedge clk); #1;
    sq_in_a = sq; iters_a = it; start_a = 1'b1; c = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic launch_b(input logic [31:0] sq, input logic [31:0] it, output int c);
    @(posedge clk); #1;
    sq_in_b = sq; iters_b = it; start_b = 1'b1; c = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int n);
    for (int i = 0; i < 200 && nd_a < n; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
    total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
    total++; if (sqr_start_a !== 1'b0) $display("FAIL reset_sqr_start: got %b want 0", sqr_start_a); else passed++;
    total++; if (sq_out_a !== '0) $display("FAIL reset_sq_out: got %h want 0", sq_out_a); else passed++;
    total++; if (sqr_in_a !== '0) $display("FAIL reset_sqr_in: got %h want 0", sqr_in_a); else passed++;
    total++; if (iter_count_a !== '0) $display("FAIL reset_iter_count: got %0d want 0", iter_count_a); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (busy_a !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_nominal;
    int c;
    clear_mon();
    launch_a(32'h0002_0001, 32'd5, c);
    total++; if (busy_a !== 1'b1) $display("FAIL nom_busy_rise: got %b want 1", busy_a); else passed++;
    wait_done_a(1);
    total++; if (nd_a !== 1) $display("FAIL nom_done_count: got %0d want 1", nd_a); else passed++;
    total++; if (ns_a !== 5) $display("FAIL nom_sqr_start_count: got %0d want 5", ns_a); else passed++;
    total++; if (gap_bad_a !== 0) $display("FAIL nom_start_spacing: got %0d bad gaps want 0", gap_bad_a); else passed++;
    total++; if (first_st_a !== c + 6) $display("FAIL nom_first_start_cycle: got %0d want %0d", first_st_a, c + 6); else passed++;
    total++; if (done_cyc_a !== c + 30) $display("FAIL nom_done_cycle: got %0d want %0d", done_cyc_a, c + 30); else passed++;
    total++; if (out_a !== pack4(6, 7, 5, 5)) $display("FAIL nom_sq_out: got %h want %h", out_a, pack4(6, 7, 5, 5)); else passed++;
    total++; if (cnt_a !== 32'd5) $display("FAIL nom_iter_count: got %0d want 5", cnt_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL nom_busy_fall: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_zero_iter;
    int c;
    clear_mon();
    launch_a(32'hABCD_1234, 32'd0, c);
    wait_done_a(1);
    total++; if (ns_a !== 0) $display("FAIL zero_sqr_start_count: got %0d want 0", ns_a); else passed++;
    total++; if (done_cyc_a !== c + 10) $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc_a, c + 10); else passed++;
    total++; if (out_a !== pack4(32'h1234, 32'hABCD, 0, 0)) $display("FAIL zero_sq_out: got %h want %h", out_a, pack4(32'h1234, 32'hABCD, 0, 0)); else passed++;
    total++; if (cnt_a !== 32'd0) $display("FAIL zero_iter_count: got %0d want 0", cnt_a); else passed++;
  endtask

  task automatic test_early_stop;
    int c;
    clear_mon();
    launch_a(32'h0010_0020, 32'd100, c);
    for (int i = 0; i < 100 && ns_a < 3; i++) begin
      @(posedge clk); #1;
    end
    stop_a = 1'b1;
    @(posedge clk); #1;
    stop_a = 1'b0;
    wait_done_a(1);
    total++; if (nd_a !== 1) $display("FAIL stop_done_count: got %0d want 1", nd_a); else passed++;
    total++; if (ns_a !== 3) $display("FAIL stop_sqr_start_count: got %0d want 3", ns_a); else passed++;
    total++; if (cnt_a !== 32'd3) $display("FAIL stop_iter_count: got %0d want 3", cnt_a); else passed++;
    total++; if (out_a !== pack4(32'h23, 32'h13, 3, 3)) $display("FAIL stop_sq_out: got %h want %h", out_a, pack4(32'h23, 32'h13, 3, 3)); else passed++;
  endtask

  task automatic test_ignored;
    int c;
    clear_mon();
    launch_a(32'h0002_0001, 32'd2, c);
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b1; sq_in_a = 32'hFFFF_FFFF; iters_a = 32'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(1);
    repeat (20) @(posedge clk);
    #1;
    total++; if (nd_a !== 1) $display("FAIL busy_start_done_count: got %0d want 1", nd_a); else passed++;
    total++; if (out_a !== pack4(3, 4, 2, 2)) $display("FAIL busy_start_sq_out: got %h want %h", out_a, pack4(3, 4, 2, 2)); else passed++;
    spur_a = 1'b1;
    @(posedge clk); #1;
    spur_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (iter_count_a !== 32'd2) $display("FAIL idle_valid_iter_count: got %0d want 2", iter_count_a); else passed++;
    total++; if (nd_a !== 1) $display("FAIL idle_valid_done_count: got %0d want 1", nd_a); else passed++;
    clear_mon();
    launch_a(32'h0003_0004, 32'd2, c);
    for (int i = 0; i < 40 && sqr_start_a !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    spur_a = 1'b1;
    @(posedge clk); #1;
    spur_a = 1'b0;
    wait_done_a(1);
    total++; if (ns_a !== 2) $display("FAIL issue_valid_start_count: got %0d want 2", ns_a); else passed++;
    total++; if (cnt_a !== 32'd2) $display("FAIL issue_valid_iter_count: got %0d want 2", cnt_a); else passed++;
    total++; if (out_a !== pack4(6, 5, 2, 2)) $display("FAIL issue_valid_sq_out: got %h want %h", out_a, pack4(6, 5, 2, 2)); else passed++;
  endtask

  task automatic test_back_to_back;
    int c;
    clear_mon();
    launch_a(32'h0001_0001, 32'd1, c);
    for (int i = 0; i < 100 && done_a !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++; if (busy_a !== 1'b0) $display("FAIL b2b_busy_after_done: got %b want 0", busy_a); else passed++;
    start_a = 1'b1; sq_in_a = 32'h0005_0007; iters_a = 32'd2;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(2);
    total++; if (nd_a !== 2) $display("FAIL b2b_done_count: got %0d want 2", nd_a); else passed++;
    total++; if (out_log_a[0] !== pack4(2, 2, 1, 1)) $display("FAIL b2b_first_sq_out: got %h want %h", out_log_a[0], pack4(2, 2, 1, 1)); else passed++;
    total++; if (cnt_log_a[0] !== 32'd1) $display("FAIL b2b_first_iter_count: got %0d want 1", cnt_log_a[0]); else passed++;
    total++; if (out_log_a[1] !== pack4(9, 7, 2, 2)) $display("FAIL b2b_second_sq_out: got %h want %h", out_log_a[1], pack4(9, 7, 2, 2)); else passed++;
    total++; if (cnt_log_a[1] !== 32'd2) $display("FAIL b2b_second_iter_count: got %0d want 2", cnt_log_a[1]); else passed++;
  endtask

  task automatic test_reset_mid;
    int c;
    clear_mon();
    launch_a(32'h0000_0001, 32'd100, c);
    for (int i = 0; i < 100 && ns_a < 2; i++) begin
      @(posedge clk); #1;
    end
    #3 reset = 1'b1;
    #1;
    total++; if (busy_a !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_a); else passed++;
    total++; if (sqr_start_a !== 1'b0) $display("FAIL midrst_sqr_start: got %b want 0", sqr_start_a); else passed++;
    total++; if (sq_out_a !== '0) $display("FAIL midrst_sq_out: got %h want 0", sq_out_a); else passed++;
    total++; if (sqr_in_a !== '0) $display("FAIL midrst_sqr_in: got %h want 0", sqr_in_a); else passed++;
    total++; if (iter_count_a !== '0) $display("FAIL midrst_iter_count: got %0d want 0", iter_count_a); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if (nd_a !== 0) $display("FAIL midrst_no_done: got %0d want 0", nd_a); else passed++;
    launch_a(32'h0000_0000, 32'd1, c);
    wait_done_a(1);
    total++; if (nd_a !== 1) $display("FAIL midrst_rerun_done: got %0d want 1", nd_a); else passed++;
    total++; if (out_a !== pack4(1, 1, 1, 1)) $display("FAIL midrst_rerun_sq_out: got %h want %h", out_a, pack4(1, 1, 1, 1)); else passed++;
    total++; if (cnt_a !== 32'd1) $display("FAIL midrst_rerun_iter_count: got %0d want 1", cnt_a); else passed++;
  endtask

  task automatic test_zero_stages;
    int c;
    clear_mon();
    launch_b(32'h0000_00FF, 32'd0, c);
    for (int i = 0; i < 50 && nd_b < 1; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    total++; if (ns_b !== 0) $display("FAIL s0_zero_start_count: got %0d want 0", ns_b); else passed++;
    total++; if (done_cyc_b !== c + 2) $display("FAIL s0_zero_done_cycle: got %0d want %0d", done_cyc_b, c + 2); else passed++;
    total++; if (out_b !== pack4(32'hFF, 0, 0, 0)) $display("FAIL s0_zero_sq_out: got %h want %h", out_b, pack4(32'hFF, 0, 0, 0)); else passed++;
    clear_mon();
    launch_b(32'h0000_0000, 32'd3, c);
    for (int i = 0; i < 100 && nd_b < 1; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    total++; if (first_st_b !== c + 2) $display("FAIL s0_first_start_cycle: got %0d want %0d", first_st_b, c + 2); else passed++;
    total++; if (ns_b !== 3 || gap_bad_b !== 0) $display("FAIL s0_starts: got %0d pulses %0d bad gaps want 3/0", ns_b, gap_bad_b); else passed++;
    total++; if (done_cyc_b !== c + 14) $display("FAIL s0_done_cycle: got %0d want %0d", done_cyc_b, c + 14); else passed++;
    total++; if (out_b !== pack4(3, 3, 3, 3) || cnt_b !== 32'd3) $display("FAIL s0_result: got %h/%0d want %h/3", out_b, cnt_b, pack4(3, 3, 3, 3)); else passed++;
    total++; if (busy_b !== 1'b0) $display("FAIL s0_busy_fall: got %b want 0", busy_b); else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_iter();
    test_early_stop();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_zero_stages();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
